// File: rtl/gpio_digit_tx.sv
`default_nettype none
// ============================================================================
// Module   : gpio_digit_tx
// Purpose  : FPGA->MCU digit transmitter; FIFO-buffered 4-phase req/ack link.
// Revision : 1.0  initial release
// ============================================================================
module gpio_digit_tx #(
    parameter int DEPTH   = 4,
    parameter int SETUP   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     send,
    input  logic [3:0]               send_digit,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               out_digit,
    output logic                     out_req,
    input  logic                     ack_in,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_tmax  = (TIMEOUT > SETUP) ? TIMEOUT : SETUP;
    localparam int c_tmr_w = $clog2(c_tmax) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_tmr_w-1:0]   timer_q, timer_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]           out_digit_q, out_digit_d;
    logic                 out_req_q, out_req_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 ack_meta_q, ack_s_q;
    logic [3:0]           mem_q [DEPTH];
    logic                 push, pop, full_w;

    assign full_w      = (count_q == c_cnt_w'(DEPTH));
    assign push        = send && !full_w;
    assign full        = full_w;
    assign count       = count_q;
    assign out_digit   = out_digit_q;
    assign out_req     = out_req_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE) || (count_q != '0);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        out_digit_d   = out_digit_q;
        timeout_err_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A still-high ack from the previous word blocks the next pop.
                if (count_q != '0 && !ack_s_q) begin
                    pop         = 1'b1;
                    out_digit_d = mem_q[rd_ptr_q];
                    timer_d     = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_q == c_tmr_w'(SETUP - 1)) begin
                    timer_d = '0;
                    state_d = ST_REQ;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_REQ: begin
                if (ack_s_q) begin
                    timer_d = '0;
                    state_d = ST_RELEASE;
                end else if (timer_q == c_tmr_w'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_RELEASE: begin
                if (!ack_s_q) begin
                    state_d = ST_IDLE;
                end else if (timer_q == c_tmr_w'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_req_d = (state_d == ST_REQ);
        wr_ptr_d  = push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_digit_q   <= '0;
            out_req_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ack_meta_q    <= 1'b0;
            ack_s_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_digit_q   <= out_digit_d;
            out_req_q     <= out_req_d;
            timeout_err_q <= timeout_err_d;
            ack_meta_q    <= ack_in;
            ack_s_q       <= ack_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= send_digit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_digit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_digit_tx
// Purpose  : Self-checking bench for gpio_digit_tx with an MCU ack model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpio_digit_tx;

    localparam int DEPTH   = 4;
    localparam int SETUP   = 2;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send = 1'b0;
    logic [3:0] send_digit = 4'h0;
    logic       full, out_req, busy, timeout_err, ack_in;
    logic [2:0] count;
    logic [3:0] out_digit;

    logic mcu_ack = 1'b0;
    logic ack_force = 1'b0;
    logic mcu_en = 1'b0;
    int   ack_dly = 3;
    int   rel_dly = 2;
    assign ack_in = mcu_ack | ack_force;

    int         checks = 0;
    int         failures = 0;
    int         err_cnt = 0;
    logic [3:0] exp_q [$];
    logic       prev_req = 1'b0;

    typedef struct {
        logic       snd;
        logic [3:0] dig;
        logic       acc;
        int         exp_cnt;
        logic       exp_full;
    } vec_t;
    vec_t vecs [6];

    gpio_digit_tx #(.DEPTH(DEPTH), .SETUP(SETUP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .send(send), .send_digit(send_digit),
        .full(full), .count(count), .out_digit(out_digit), .out_req(out_req),
        .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_send(input logic [3:0] d, input logic acc);
        send       = 1'b1;
        send_digit = d;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!out_req && n < 100) begin
            tick();
            n++;
        end
        check(name, out_req, 1);
    endtask

    // MCU side: raise ack some cycles after req, drop it some cycles after req falls
    initial begin
        forever begin
            @(negedge clk);
            if (mcu_en && out_req && !mcu_ack) begin
                repeat (ack_dly - 1) @(negedge clk);
                mcu_ack = 1'b1;
                while (out_req) @(negedge clk);
                repeat (rel_dly) @(negedge clk);
                mcu_ack = 1'b0;
            end
        end
    end

    // Scoreboard: every req rise must carry the oldest outstanding digit
    initial begin
        forever begin
            @(negedge clk);
            if (timeout_err) err_cnt++;
            if (out_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", out_digit);
                end else begin
                    check("word_order", out_digit, exp_q.pop_front());
                end
            end
            prev_req = out_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;
        vecs[0] = '{1'b1, 4'h1, 1'b1, 1, 1'b0};
        vecs[1] = '{1'b1, 4'h2, 1'b1, 1, 1'b0};
        vecs[2] = '{1'b1, 4'h3, 1'b1, 2, 1'b0};
        vecs[3] = '{1'b1, 4'h4, 1'b1, 3, 1'b0};
        vecs[4] = '{1'b1, 4'h5, 1'b1, 4, 1'b1};
        vecs[5] = '{1'b1, 4'h6, 1'b0, 4, 1'b1};

        repeat (2) tick();
        reset = 1'b1;
        check("rst_out_req", out_req, 0);
        check("rst_out_digit", out_digit, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single word latency and ack timing
        mcu_en = 1'b1; ack_dly = 3; rel_dly = 2;
        drive_send(4'h7, 1'b1);
        tick(); send = 1'b0;
        check("t1_count_E0", count, 1);
        tick();
        check("t1_digit_E1", out_digit, 7);
        check("t1_req_E1", out_req, 0);
        tick();
        check("t1_req_E2", out_req, 0);
        tick();
        check("t1_req_E3", out_req, 1);
        n = 0;
        while (!ack_in && n < 50) begin
            tick();
            n++;
        end
        check("t1_ack_seen", ack_in, 1);
        tick();
        check("t1_req_K1", out_req, 1);
        tick();
        check("t1_req_K2", out_req, 0);
        wait_idle("t1_idle");
        check("t1_count_end", count, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_no_err", err_cnt, 0);

        // Back-to-back sends overflowing the FIFO
        ack_dly = 6; rel_dly = 4;
        for (int i = 0; i < 6; i++) begin
            drive_send(vecs[i].dig, vecs[i].acc);
            tick();
            check($sformatf("t2_count_%0d", i), count, vecs[i].exp_cnt);
            check($sformatf("t2_full_%0d", i), full, vecs[i].exp_full);
        end
        send = 1'b0;
        wait_idle("t2_idle");
        check("t2_count_end", count, 0);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_no_err", err_cnt, 0);

        // Ack never comes: timeout then next word
        mcu_en = 1'b0;
        errs = err_cnt;
        drive_send(4'hA, 1'b1);
        tick();
        drive_send(4'hB, 1'b1);
        tick(); send = 1'b0;
        wait_req("t3_req_rise");
        n = 0;
        while (out_req && n < 100) begin
            tick();
            n++;
        end
        check("t3_req_cycles", n, TIMEOUT);
        check("t3_err_pulse", timeout_err, 1);
        tick();
        check("t3_err_one_cycle", timeout_err, 0);
        mcu_en = 1'b1;
        wait_idle("t3_idle");
        check("t3_err_count", err_cnt - errs, 1);
        check("t3_sb_empty", exp_q.size(), 0);

        // Ack stuck high blocks the pop
        ack_force = 1'b1;
        repeat (3) tick();
        drive_send(4'h9, 1'b1);
        tick(); send = 1'b0;
        repeat (6) tick();
        check("t4_count_held", count, 1);
        check("t4_req_low", out_req, 0);
        check("t4_busy", busy, 1);
        check("t4_digit_held", out_digit, 4'hB);
        ack_force = 1'b0;
        wait_idle("t4_idle");
        check("t4_count_end", count, 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // Push while full coinciding with a pop is dropped
        ack_force = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            drive_send(4'(i + 1), 1'b1);
            tick();
        end
        send = 1'b0;
        check("t6_count_full", count, 4);
        check("t6_full", full, 1);
        ack_force = 1'b0;
        tick();
        tick();
        check("t6_count_prepop", count, 4);
        drive_send(4'hF, 1'b0);
        tick(); send = 1'b0;
        check("t6_count_popped", count, 3);
        check("t6_full_clear", full, 0);
        wait_idle("t6_idle");
        check("t6_sb_empty", exp_q.size(), 0);

        // Reset mid-handshake discards everything
        mcu_en = 1'b0;
        errs = err_cnt;
        drive_send(4'h5, 1'b1);
        tick();
        drive_send(4'h6, 1'b0);
        tick();
        drive_send(4'h7, 1'b0);
        tick(); send = 1'b0;
        wait_req("t5_req_rise");
        check("t5_count_q2", count, 2);
        reset = 1'b0;
        tick();
        check("t5_req_low", out_req, 0);
        check("t5_count0", count, 0);
        check("t5_full0", full, 0);
        check("t5_busy0", busy, 0);
        check("t5_digit0", out_digit, 0);
        reset = 1'b1;
        mcu_en = 1'b1;
        repeat (60) tick();
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_count_end", count, 0);
        check("t5_busy_end", busy, 0);
        check("t5_no_err", err_cnt - errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_digit_tx.md
Name: gpio_digit_tx

Overview:
Transmit side of the MCU/FPGA GPIO digit link. Forwards 4-bit status digits from FPGA logic (e.g. motor-position-reached, digit-displayed acks) to the microcontroller. Uses a 4-phase req/ack handshake on GPIO pins.
Buffers digits in a small FIFO so producers never stall. Sits beside the GPIO digit receiver in the top level, driving the FPGA→MCU pins.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2.
SETUP, 2, cycles out_digit is held stable before out_req rises; ≥1.
TIMEOUT, 1024, cycles waited for each ack edge before aborting the word; ≥4.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low reset.
send  in  1  push strobe; send_digit is enqueued on the rising edge where send=1 and full=0.
send_digit  in  4  digit to enqueue.
full  out  1  FIFO holds DEPTH entries.
count  out  $clog2(DEPTH)+1  current FIFO occupancy.
out_digit  out  4  digit pins to MCU.
out_req  out  1  request pin to MCU.
ack_in  in  1  acknowledge pin from MCU; asynchronous.
busy  out  1  state≠IDLE or count≠0.
timeout_err  out  1  one-cycle pulse on each aborted word.

Behaviour:
- Reset (reset=0 at a rising edge): out_digit=0, out_req=0, timeout_err=0, count=0, full=0, FIFO pointers=0, state=IDLE, synchronizer flops=0, timer=0. Takes effect regardless of state; an in-flight word and all queued words are discarded.
- ack_in passes through a 2-flop synchronizer to give ack_s. The FSM uses only ack_s.
- FIFO:
  - Push when send=1 and full=0 (full taken from the registered count).
  - A push attempted while full is dropped silently, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, REQ, RELEASE.
  - IDLE: if count≠0 and ack_s=0: pop head into out_digit, clear timer, go to SETUP. If ack_s=1, wait in IDLE; no pop.
  - SETUP: out_req=0. Timer counts up. After SETUP cycles in this state, go to REQ.
  - REQ: out_req=1. If ack_s=1: go to RELEASE, clear timer (out_req low from the next cycle). Else if timer reaches TIMEOUT−1: pulse timeout_err, go to IDLE, word dropped.
  - RELEASE: out_req=0. If ack_s=0: go to IDLE. Else if timer reaches TIMEOUT−1: pulse timeout_err, go to IDLE.
- out_digit holds its value after a handshake until the next pop; it is never cleared outside reset.
- Latency, with send sampled at edge E0 into an idle, empty block and SETUP=2:
  - out_digit valid after E1.
  - out_req high after E3.
- ack timing: with ack_in first sampled high at edge K, out_req falls after edge K+2.
- FIFO order is strictly preserved; each accepted digit is transmitted exactly once or reported with one timeout_err.
- count and full update on the same edge as the push or pop.

Test Plan:
1. Reset, send 4'h7 once; MCU model raises ack 3 cycles after req and drops it 2 cycles after req falls → out_digit=7 after E1, out_req high after E3, req low 3 edges after ack rise, busy=0 once ack_s=0 and FSM returns to IDLE.
2. Six back-to-back sends 1..6 with DEPTH=4, slow ack model → 1 popped at E1, 2–5 fill FIFO, full=1, 6 dropped. MCU receives exactly 1,2,3,4,5; count returns to 0.
3. TIMEOUT=16, ack never asserted → out_req high exactly 16 cycles, then one timeout_err pulse and out_req=0. The next queued word starts a fresh handshake.
4. ack_in stuck high while a word is queued → FSM stays in IDLE, no pop, out_req=0, count unchanged. Releasing ack → handshake proceeds normally.
5. reset driven low while out_req=1 with 2 words queued → after the next edge out_req=0, count=0, full=0, busy=0. Neither queued word is ever transmitted.
6. FIFO full, FSM pops in the same cycle as send=1 → the push is dropped and count decrements by 1.
